alu_frame_ctrl: RTL

Sequencer that owns the ALU operand and opcode registers and feeds them from a byte stream instead of switches/buttons. It accepts 3-byte command frames (opcode, data A, data B) on a valid/ready input and applies all three to the combinational ALU in one atomic update. It then captures the ALU result and returns it on a valid/ready output. It sits between a byte transport (UART RX/TX wrapper) and the existing ALU, replacing the button-driven load path in top.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/frame_timer.sv | 28 ++
 rtl/alu_frame_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, frame sequencer state type and opcode legality check.
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

  typedef enum logic [2:0] {
    ST_WAIT_OP,
    ST_WAIT_A,
    ST_WAIT_B,
    ST_EXEC,
    ST_SEND
  } frame_state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle counter; o_expire flags the cycle on which the idle limit is reached.
module frame_timer #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int NB_TIMER    = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  logic [NB_TIMER-1:0] count;

  // A clear in the same cycle (byte accepted) always beats expiry.
  assign o_expire = i_en & ~i_clr & (count == NB_TIMER'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (i_clr || !i_en || o_expire) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_frame_ctrl.sv
// Byte-stream front end for the ALU: parses opcode/A/B frames, loads the ALU atomically, returns the result.
module alu_frame_ctrl
  import alu_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 50000,
  parameter int NB_TIMER    = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_rx_ready,
  output logic [NB_DATA-1:0] o_alu_data_A,
  output logic [NB_DATA-1:0] o_alu_data_B,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_err_op,
  output logic               o_err_timeout,
  output logic [7:0]         o_frame_cnt
);

  frame_state_t state, state_next;
  logic         rx_ready, rx_ready_next;
  logic [NB_OP-1:0]   op_stage;
  logic [NB_DATA-1:0] a_stage;
  logic accept, op_legal, tx_fire, timer_en, timer_expire;

  assign accept   = i_rx_valid & rx_ready;
  assign op_legal = is_legal_op(i_rx_data[NB_OP-1:0]);
  assign tx_fire  = o_tx_valid & i_tx_ready;
  assign timer_en = (state == ST_WAIT_A) || (state == ST_WAIT_B);
  assign o_rx_ready = rx_ready;

  frame_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .NB_TIMER    (NB_TIMER)
  ) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_en     (timer_en),
    .i_clr    (accept),
    .o_expire (timer_expire)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= ST_WAIT_OP;
      rx_ready <= 1'b0;
    end else begin
      state    <= state_next;
      rx_ready <= rx_ready_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT_OP: if (accept && op_legal) state_next = ST_WAIT_A;
      ST_WAIT_A:  if (accept) state_next = ST_WAIT_B;
                  else if (timer_expire) state_next = ST_WAIT_OP;
      ST_WAIT_B:  if (accept) state_next = ST_EXEC;
                  else if (timer_expire) state_next = ST_WAIT_OP;
      ST_EXEC:    state_next = ST_SEND;
      ST_SEND:    if (tx_fire) state_next = ST_WAIT_OP;
      default:    state_next = ST_WAIT_OP;
    endcase
    // Ready is registered so it reads 0 while reset is held.
    rx_ready_next = (state_next == ST_WAIT_OP) || (state_next == ST_WAIT_A) ||
                    (state_next == ST_WAIT_B);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      op_stage      <= '0;
      a_stage       <= '0;
      o_alu_op      <= '0;
      o_alu_data_A  <= '0;
      o_alu_data_B  <= '0;
      o_tx_data     <= '0;
      o_tx_valid    <= 1'b0;
      o_err_op      <= 1'b0;
      o_err_timeout <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      o_err_op      <= accept && (state == ST_WAIT_OP) && !op_legal;
      o_err_timeout <= timer_expire;
      case (state)
        ST_WAIT_OP: if (accept && op_legal) op_stage <= i_rx_data[NB_OP-1:0];
        ST_WAIT_A:  if (accept) a_stage <= i_rx_data;
        ST_WAIT_B: begin
          if (accept) begin
            o_alu_op     <= op_stage;
            o_alu_data_A <= a_stage;
            o_alu_data_B <= i_rx_data;
          end
        end
        ST_EXEC: o_tx_data <= i_alu_result;
        ST_SEND: begin
          // Valid rises one cycle after capture; only then can a handshake occur.
          if (!o_tx_valid) begin
            o_tx_valid <= 1'b1;
          end else if (i_tx_ready) begin
            o_tx_valid  <= 1'b0;
            o_frame_cnt <= o_frame_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
